// File: rtl/clint_trap_ctrl.sv
// CLINT trap sequencer: detects ECALL/EBREAK/ext-IRQ/MRET, writes mepc/mstatus/mcause
// through the CSR write port, then redirects the PC. Define CLINT_EXT_IRQ_EN for the irq_i path.
module clint_trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);
  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;
  localparam logic [31:0] CSR_MSTATUS = 32'h300;
  localparam logic [31:0] CSR_MEPC    = 32'h341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h342;

  typedef enum logic [2:0] {
    S_IDLE, S_W_MEPC, S_W_MSTATUS, S_W_MCAUSE, S_ASSERT, S_R_MSTATUS
  } state_t;

  state_t      r_state;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_int_assert;
  logic [31:0] r_int_addr;

  logic        w_sync;
  logic        w_async;
  logic        w_mret;
  logic        w_detect;
  logic [31:0] w_async_epc;
  logic [31:0] w_mstatus_trap;
  logic [31:0] w_mstatus_mret;

  assign w_sync = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign w_mret = (inst_i == INST_MRET);

`ifdef CLINT_EXT_IRQ_EN
  assign w_async     = irq_i && global_int_en_i;
  assign w_async_epc = jump_flag_i ? jump_addr_i : inst_addr_i;
`else
  logic w_unused;
  assign w_async     = 1'b0;
  assign w_async_epc = inst_addr_i;
  assign w_unused    = ^{irq_i, global_int_en_i, jump_flag_i, jump_addr_i, CAUSE_EXT_IRQ};
`endif

  assign w_detect = (r_state == S_IDLE) && !hold_flag_i && (w_sync || w_async || w_mret);

  // Trap entry: MPIE <- MIE, MIE <- 0. MRET: MIE <- MPIE, MPIE <- 1.
  assign w_mstatus_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                           csr_mstatus_i[2:0]};
  assign w_mstatus_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                           csr_mstatus_i[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cause      <= '0;
      r_epc        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
    end else begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_detect) begin
            r_we <= 1'b1;
            if (w_sync) begin
              r_state <= S_W_MEPC;
              r_cause <= (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
              r_epc   <= inst_addr_i;
              r_waddr <= CSR_MEPC;
              r_wdata <= inst_addr_i;
            end else if (w_async) begin
              r_state <= S_W_MEPC;
              r_cause <= CAUSE_EXT_IRQ;
              r_epc   <= w_async_epc;
              r_waddr <= CSR_MEPC;
              r_wdata <= w_async_epc;
            end else begin
              r_state <= S_R_MSTATUS;
              r_waddr <= CSR_MSTATUS;
              r_wdata <= w_mstatus_mret;
            end
          end
        end
        S_W_MEPC: begin
          r_state <= S_W_MSTATUS;
          r_we    <= 1'b1;
          r_waddr <= CSR_MSTATUS;
          r_wdata <= w_mstatus_trap;
        end
        S_W_MSTATUS: begin
          r_state <= S_W_MCAUSE;
          r_we    <= 1'b1;
          r_waddr <= CSR_MCAUSE;
          r_wdata <= r_cause;
        end
        S_W_MCAUSE: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= csr_mtvec_i;
        end
        S_R_MSTATUS: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= csr_mepc_i;
        end
        S_ASSERT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // r_epc is the saved exception PC; the mepc write carries it out on the first write cycle.
  assign csr_we_o     = r_we;
  assign csr_waddr_o  = r_waddr;
  assign csr_wdata_o  = (r_state == S_W_MEPC) ? r_epc : r_wdata;
  assign int_assert_o = r_int_assert;
  assign int_addr_o   = r_int_addr;
  assign hold_flag_o  = (r_state != S_IDLE) || w_detect;
endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: hand-computed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_clint_trap_ctrl;
`ifdef CLINT_EXT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] ECALL = 32'h00000073, EBREAK = 32'h00100073, MRET = 32'h30200073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0, rst, irq_i, jump_flag_i, hold_flag_i, global_int_en_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic csr_we_o, hold_flag_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

  clint_trap_ctrl dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .global_int_en_i(global_int_en_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
    .int_addr_o(int_addr_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic we; logic [31:0] wa; logic [31:0] wd; logic hold; logic as; logic [31:0] ia;
  } out_t;

  typedef struct {
    logic [31:0] inst, pc; logic irq, gie, jf; logic [31:0] ja, mst, mtvec, mepc;
    logic det, mret; logic [31:0] epc, mstw, cause, tgt;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  vec_t vt[8];
  out_t q[$];

  function automatic out_t o(logic we, logic [31:0] wa, logic [31:0] wd, logic hold, logic as,
                             logic [31:0] ia);
    out_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.hold = hold; r.as = as; r.ia = ia;
    return r;
  endfunction

  function automatic vec_t mk(logic [31:0] inst, pc, logic irq, gie, jf, logic [31:0] ja, mst,
                              mtvec, mepc, logic det, mret, logic [31:0] epc, mstw, cause, tgt);
    vec_t v;
    v.inst = inst; v.pc = pc; v.irq = irq; v.gie = gie; v.jf = jf; v.ja = ja; v.mst = mst;
    v.mtvec = mtvec; v.mepc = mepc; v.det = det; v.mret = mret; v.epc = epc; v.mstw = mstw;
    v.cause = cause; v.tgt = tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input out_t e);
    out_t g;
    g = o(csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, int_assert_o, int_addr_o);
    n_cmp++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got we=%0b wa=%h wd=%h hold=%0b as=%0b ia=%h, want we=%0b wa=%h wd=%h hold=%0b as=%0b ia=%h",
               nm, g.we, g.wa, g.wd, g.hold, g.as, g.ia, e.we, e.wa, e.wd, e.hold, e.as, e.ia);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp(input string nm, input out_t e);
    @(negedge clk);
    chk(nm, e);
  endtask

  // Called one cycle after a trap was detected, with inst_i already changed to NOP.
  task automatic run_trap(input string nm, input logic [31:0] epc, mstw, cause, tgt);
    smp({nm, " mepc"}, o(1, 32'h341, epc, 1, 0, 0));     nxt();
    smp({nm, " mstatus"}, o(1, 32'h300, mstw, 1, 0, 0)); nxt();
    smp({nm, " mcause"}, o(1, 32'h342, cause, 1, 0, 0)); nxt();
    smp({nm, " assert"}, o(0, 0, 0, 1, 1, tgt));         nxt();
    smp({nm, " idle"}, o(0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_mret(input string nm, input logic [31:0] mstw, tgt);
    smp({nm, " mstatus"}, o(1, 32'h300, mstw, 1, 0, 0)); nxt();
    smp({nm, " assert"}, o(0, 0, 0, 1, 1, tgt));         nxt();
    smp({nm, " idle"}, o(0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle_in();
    inst_i = NOP; irq_i = 0; jump_flag_i = 0; hold_flag_i = 0;
  endtask

  // Reference model: trap rules expressed as mstatus bit arithmetic and a queue of future outputs.
  function automatic logic [31:0] ms_trap(logic [31:0] m);
    return (m & ~32'h88) | (32'(m[3]) << 7);
  endfunction
  function automatic logic [31:0] ms_mret(logic [31:0] m);
    return (m & ~32'h88) | 32'h80 | (32'(m[7]) << 3);
  endfunction

  task automatic model_step(output out_t e);
    logic sync, asy, mr;
    if (q.size() != 0) begin
      e = q.pop_front();
      return;
    end
    sync = !hold_flag_i && (inst_i == ECALL || inst_i == EBREAK);
    asy  = !hold_flag_i && IRQ_EN && irq_i && global_int_en_i;
    mr   = !hold_flag_i && inst_i == MRET;
    e = o(0, 0, 0, sync || asy || mr, 0, 0);
    if (sync || asy) begin
      q.push_back(o(1, 32'h341, sync ? inst_addr_i : (jump_flag_i ? jump_addr_i : inst_addr_i),
                    1, 0, 0));
      q.push_back(o(1, 32'h300, ms_trap(csr_mstatus_i), 1, 0, 0));
      q.push_back(o(1, 32'h342, sync ? (inst_i == ECALL ? 32'd11 : 32'd3) : 32'h8000000B,
                    1, 0, 0));
      q.push_back(o(0, 0, 0, 1, 1, csr_mtvec_i));
    end else if (mr) begin
      q.push_back(o(1, 32'h300, ms_mret(csr_mstatus_i), 1, 0, 0));
      q.push_back(o(0, 0, 0, 1, 1, csr_mepc_i));
    end
  endtask

  initial begin
    out_t e;
    logic prev_as;
    //      inst    pc        irq gie jf ja        mst           mtvec     mepc      det     mret epc       mstw          cause         tgt
    vt[0] = mk(ECALL,  32'h100, 0, 0, 0, 32'h0,   32'h8,        32'h80,   32'h0,   1,      0, 32'h100,  32'h80,       32'd11,       32'h80);
    vt[1] = mk(EBREAK, 32'h40,  0, 1, 0, 32'h0,   32'h88,       32'h1000, 32'h0,   1,      0, 32'h40,   32'h80,       32'd3,        32'h1000);
    vt[2] = mk(MRET,   32'h300, 0, 0, 0, 32'h0,   32'h80,       32'h80,   32'h104, 1,      1, 32'h0,    32'h88,       32'h0,        32'h104);
    vt[3] = mk(MRET,   32'h300, 0, 0, 0, 32'h0,   32'h1808,     32'h80,   32'h2000,1,      1, 32'h0,    32'h1880,     32'h0,        32'h2000);
    vt[4] = mk(NOP,    32'h300, 1, 1, 1, 32'h200, 32'h8,        32'h80,   32'h0,   IRQ_EN, 0, 32'h200,  32'h80,       32'h8000000B, 32'h80);
    vt[5] = mk(NOP,    32'h300, 1, 0, 1, 32'h200, 32'h0,        32'h80,   32'h0,   0,      0, 32'h0,    32'h0,        32'h0,        32'h0);
    vt[6] = mk(EBREAK, 32'h44,  1, 1, 1, 32'h200, 32'h8,        32'hC0,   32'h0,   1,      0, 32'h44,   32'h80,       32'd3,        32'hC0);
    vt[7] = mk(ECALL,  32'h7C,  0, 0, 0, 32'h0,   32'hFFFFFFF7, 32'h400,  32'h0,   1,      0, 32'h7C,   32'hFFFFFF77, 32'd11,       32'h400);

    rst = 1; idle_in(); global_int_en_i = 0; inst_addr_i = 0; jump_addr_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
    nxt(); nxt();
    smp("reset", o(0, 0, 0, 0, 0, 0));
    nxt(); rst = 0;

    foreach (vt[i]) begin
      inst_i = vt[i].inst; inst_addr_i = vt[i].pc; irq_i = vt[i].irq;
      global_int_en_i = vt[i].gie; jump_flag_i = vt[i].jf; jump_addr_i = vt[i].ja;
      csr_mstatus_i = vt[i].mst; csr_mtvec_i = vt[i].mtvec; csr_mepc_i = vt[i].mepc;
      smp($sformatf("vec%0d detect", i), o(0, 0, 0, vt[i].det, 0, 0));
      nxt(); idle_in();
      if (vt[i].det && vt[i].mret) run_mret($sformatf("vec%0d", i), vt[i].mstw, vt[i].tgt);
      else if (vt[i].det) run_trap($sformatf("vec%0d", i), vt[i].epc, vt[i].mstw, vt[i].cause, vt[i].tgt);
      else smp($sformatf("vec%0d none", i), o(0, 0, 0, 0, 0, 0));
      nxt();
    end

    // ECALL held off by hold_flag_i for 3 cycles
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80; global_int_en_i = 0;
    inst_i = ECALL; inst_addr_i = 32'h600; hold_flag_i = 1;
    for (int k = 0; k < 3; k++) begin
      smp($sformatf("held%0d", k), o(0, 0, 0, 0, 0, 0)); nxt();
    end
    hold_flag_i = 0;
    smp("hold release detect", o(0, 0, 0, 1, 0, 0)); nxt(); idle_in();
    run_trap("hold release", 32'h600, 32'h80, 32'd11, 32'h80); nxt();

    // irq pulsed mid-sequence is ignored
    inst_i = ECALL; inst_addr_i = 32'h700; global_int_en_i = 1;
    smp("irqmid detect", o(0, 0, 0, 1, 0, 0)); nxt(); idle_in();
    smp("irqmid mepc", o(1, 32'h341, 32'h700, 1, 0, 0)); nxt(); irq_i = 1;
    smp("irqmid mstatus", o(1, 32'h300, 32'h80, 1, 0, 0)); nxt(); irq_i = 0;
    smp("irqmid mcause", o(1, 32'h342, 32'd11, 1, 0, 0)); nxt();
    smp("irqmid assert", o(0, 0, 0, 1, 1, 32'h80)); nxt();
    smp("irqmid idle", o(0, 0, 0, 0, 0, 0)); nxt();

    // reset during W_MSTATUS aborts the sequence
    inst_i = ECALL; inst_addr_i = 32'h500;
    smp("rstmid detect", o(0, 0, 0, 1, 0, 0)); nxt(); idle_in();
    smp("rstmid mepc", o(1, 32'h341, 32'h500, 1, 0, 0)); nxt();
    smp("rstmid mstatus", o(1, 32'h300, 32'h80, 1, 0, 0));
    rst = 1; nxt(); rst = 0;
    smp("rstmid cleared", o(0, 0, 0, 0, 0, 0)); nxt();
    smp("rstmid no assert", o(0, 0, 0, 0, 0, 0)); nxt();

    // randomized bursts against the reference model
    for (int b = 0; b < 6; b++) begin
      rst = 1; idle_in(); nxt(); rst = 0; q.delete(); prev_as = 0;
      csr_mstatus_i = $urandom; csr_mtvec_i = $urandom; csr_mepc_i = $urandom;
      for (int c = 0; c < 300; c++) begin
        case ($urandom_range(0, 9))
          0: inst_i = ECALL;
          1: inst_i = EBREAK;
          2: inst_i = MRET;
          default: inst_i = $urandom;
        endcase
        inst_addr_i = $urandom; jump_addr_i = $urandom; jump_flag_i = 1'($urandom);
        irq_i = ($urandom_range(0, 3) == 0); global_int_en_i = 1'($urandom);
        hold_flag_i = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        model_step(e);
        chk($sformatf("rand b%0d c%0d", b, c), e);
        n_cmp++;
        if (prev_as && int_assert_o) begin
          n_err++;
          $display("FAIL rand b%0d c%0d assert_twice: got int_assert_o=1 two cycles running, want single pulse", b, c);
        end
        prev_as = int_assert_o;
        nxt();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
